// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, async-read ROM request, 2-entry fetch FIFO,
// valid/ready delivery to decode, redirect flush and halt-on-EBREAK.
module instr_fetch #(
   parameter int unsigned                   ADDR_W     = 5,
   parameter int unsigned                   INSTR_W    = 32,
   parameter logic [ADDR_W+1:0]             RESET_PC   = '0,
   parameter logic [INSTR_W-1:0]            HALT_INSTR = 32'h00100073
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [INSTR_W-1:0]  imem_q,
   input  logic                redirect_valid,
   input  logic [ADDR_W+1:0]   redirect_pc,
   output logic                if_valid,
   input  logic                if_ready,
   output logic [INSTR_W-1:0]  if_instr,
   output logic [ADDR_W+1:0]   if_pc,
   output logic                halted
);

   localparam int unsigned PC_W = ADDR_W + 2;

   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] fifo_instr [2];
   logic [PC_W-1:0]    fifo_pc    [2];
   logic               rd_ptr;
   logic               wr_ptr;
   logic [1:0]         count;
   logic               halt_seen;
   logic               pop;
   logic               push;

   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      pop  = (count != 2'd0) && if_ready;
      push = !redirect_valid && !halt_seen && ((count != 2'd2) || pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= RESET_PC & ~PC_W'(3);
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         count     <= '0;
         halt_seen <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
      end else if (redirect_valid) begin
         // Flush wins over any pop this cycle; pointers realign so the next
         // push lands at the head.
         pc        <= redirect_pc & ~PC_W'(3);
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         count     <= '0;
         halt_seen <= 1'b0;
      end else begin
         if (push) begin
            fifo_instr[wr_ptr] <= imem_q;
            fifo_pc[wr_ptr]    <= pc;
            wr_ptr             <= ~wr_ptr;
            pc                 <= pc + PC_W'(4);
            if (imem_q == HALT_INSTR)
               halt_seen <= 1'b1;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign imem_addr = pc[PC_W-1:2];
   assign if_valid  = (count != 2'd0);
   assign if_instr  = fifo_instr[rd_ptr];
   assign if_pc     = fifo_pc[rd_ptr];
   assign halted    = halt_seen && (count == 2'd0);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: ROM model word i = 0x1000+i, outputs sampled
// on the falling edge, inputs driven on the falling edge.
module tb_instr_fetch;

   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned INSTR_W = 32;
   localparam logic [31:0] HALT    = 32'h00100073;

   logic                clk;
   logic                rst_n;
   logic [ADDR_W-1:0]   imem_addr;
   logic [INSTR_W-1:0]  imem_q;
   logic                redirect_valid;
   logic [ADDR_W+1:0]   redirect_pc;
   logic                if_valid;
   logic                if_ready;
   logic [INSTR_W-1:0]  if_instr;
   logic [ADDR_W+1:0]   if_pc;
   logic                halted;

   logic [31:0] rom [32];
   int unsigned err_cnt;
   int unsigned chk_cnt;

   instr_fetch #(
      .ADDR_W     (ADDR_W),
      .INSTR_W    (INSTR_W),
      .RESET_PC   (7'd0),
      .HALT_INSTR (HALT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_q         (imem_q),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .halted         (halted)
   );

   assign imem_q = rom[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic head(input string tag, input logic [31:0] pc_exp, input logic [31:0] instr_exp);
      check({tag, "_valid"}, 32'(if_valid), 32'd1);
      check({tag, "_pc"},    32'(if_pc),    pc_exp);
      check({tag, "_instr"}, if_instr,      instr_exp);
   endtask

   initial begin
      err_cnt        = 0;
      chk_cnt        = 0;
      for (int i = 0; i < 32; i++) rom[i] = 32'h1000 + 32'(i);
      rst_n          = 1'b0;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // reset state
      tick();
      check("rst_valid",  32'(if_valid),  32'd0);
      check("rst_instr",  if_instr,       32'd0);
      check("rst_pc",     32'(if_pc),     32'd0);
      check("rst_halted", 32'(halted),    32'd0);
      check("rst_addr",   32'(imem_addr), 32'd0);

      // straight-line fetch, first valid one cycle after release
      rst_n = 1'b1;
      check("rel_valid", 32'(if_valid), 32'd0);
      tick();
      head("seq0", 32'd0, 32'h1000);
      check("seq0_addr", 32'(imem_addr), 32'd1);
      tick();
      head("seq1", 32'd4, 32'h1001);
      tick();
      head("seq2", 32'd8, 32'h1002);

      // stall 5 cycles with head at PC 8
      if_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         head("stall", 32'd8, 32'h1002);
         if (c >= 1) check("stall_addr", 32'(imem_addr), 32'd4);
      end
      if_ready = 1'b1;
      tick();
      head("rel12", 32'd12, 32'h1003);
      tick();
      head("rel16", 32'd16, 32'h1004);

      // redirect to 0x45 with FIFO full (entries 16, 20)
      redirect_valid = 1'b1;
      redirect_pc    = 7'h45;
      tick();
      redirect_valid = 1'b0;
      check("redir_valid", 32'(if_valid),  32'd0);
      check("redir_addr",  32'(imem_addr), 32'd17);
      tick();
      head("redir_tgt", 32'h44, 32'h1011);

      // wrap past top word
      redirect_valid = 1'b1;
      redirect_pc    = 7'd120;
      tick();
      redirect_valid = 1'b0;
      check("wrap_bubble", 32'(if_valid), 32'd0);
      tick();
      head("wrap120", 32'd120, 32'h101E);
      tick();
      head("wrap124", 32'd124, 32'h101F);
      tick();
      head("wrap0",   32'd0,   32'h1000);

      // halt at PC 12
      rom[3]         = HALT;
      redirect_valid = 1'b1;
      redirect_pc    = 7'd0;
      tick();
      redirect_valid = 1'b0;
      check("halt_bubble", 32'(if_valid), 32'd0);
      tick();
      head("halt0", 32'd0, 32'h1000);
      tick();
      head("halt4", 32'd4, 32'h1001);
      tick();
      head("halt8", 32'd8, 32'h1002);
      tick();
      head("halt12", 32'd12, HALT);
      check("halt12_halted", 32'(halted), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("halted_valid", 32'(if_valid), 32'd0);
         check("halted_flag",  32'(halted),   32'd1);
      end
      check("halted_addr", 32'(imem_addr), 32'd4);
      redirect_valid = 1'b1;
      redirect_pc    = 7'd0;
      tick();
      redirect_valid = 1'b0;
      check("resume_halted", 32'(halted),   32'd0);
      check("resume_valid",  32'(if_valid), 32'd0);
      tick();
      head("resume0", 32'd0, 32'h1000);

      // async reset with FIFO full
      if_ready = 1'b0;
      tick();
      head("full_pre", 32'd0, 32'h1000);
      check("full_addr", 32'(imem_addr), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid",  32'(if_valid),  32'd0);
      check("arst_halted", 32'(halted),    32'd0);
      check("arst_addr",   32'(imem_addr), 32'd0);
      check("arst_pc",     32'(if_pc),     32'd0);
      tick();
      rom[3]   = 32'h1003;
      rst_n    = 1'b1;
      if_ready = 1'b1;
      tick();
      head("restart0", 32'd0, 32'h1000);
      tick();
      head("restart4", 32'd4, 32'h1001);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front end: the requesting side of the instruction-memory read port. Holds the program counter, drives the word address into the asynchronous-read instruction ROM, captures the returned word into a 2-entry FIFO, and presents instructions to decode through a valid/ready handshake. Handles branch/jump redirect (with flush) and stops fetching on a halt instruction.

## Interface
- ADDR_W, 5, ROM word-address width; byte PC width is ADDR_W+2
- INSTR_W, 32, instruction width
- RESET_PC, 0, byte PC after reset (low 2 bits ignored)
- HALT_INSTR, 32'h00100073 (EBREAK), instruction that ends fetching
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2]
- imem_q  in  INSTR_W  ROM read data, combinational from imem_addr, same cycle
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  ADDR_W+2  redirect byte target
- if_valid  out  1  FIFO head valid
- if_ready  in  1  decode accepts head
- if_instr  out  INSTR_W  head instruction
- if_pc  out  ADDR_W+2  head byte PC
- halted  out  1  halt fetched, FIFO drained

## Operation
- State: pc (ADDR_W+2 bits), 2-entry FIFO {instr, pc}, count (0..2), halt_seen.
- pop = if_valid & if_ready.
- push = !redirect_valid & !halt_seen & (count<2 | pop); pushes {imem_q, pc}; pc <= pc+4.
- pc arithmetic modulo 2^(ADDR_W+2): top word wraps to byte 0, no error.
- Redirect (highest priority): FIFO flushed (count<=0, a concurrent pop still counts as consumed but nothing remains), pc <= {redirect_pc[ADDR_W+1:2], 2'b00}, halt_seen <= 0, no push that cycle.
- Halt: push of word == HALT_INSTR sets halt_seen; halt word itself is enqueued and delivered; no pushes afterward until redirect or reset. pc still advances past it.
- halted = halt_seen & count==0 (combinational from registers).
- if_instr/if_pc show head entry; contents when if_valid=0 are don't-care except after reset (0).
- FIFO ordering strictly program order; simultaneous push+pop at count=2 keeps count 2; at count=0 push only.

## Timing
- Reset values: pc=RESET_PC aligned, imem_addr=RESET_PC[ADDR_W+1:2], if_valid=0, if_instr=0, if_pc=0, halted=0, count=0, halt_seen=0.
- Reset asserted mid-operation: all state cleared immediately, asynchronously; in-flight entries lost.
- First edge after rst_n rises pushes word at RESET_PC; if_valid=1 the following cycle (1-cycle fetch latency).
- Sustained throughput 1 instr/cycle with if_ready=1.
- if_ready low: FIFO fills in 2 cycles then pc holds, imem_addr stable.
- Redirect at edge N: cycle N+1 imem_addr = target word, if_valid=0; target instruction valid at N+2 (1-cycle bubble).
- Outputs depend only on registers; no combinational path from if_ready or redirect_valid to if_valid/if_instr/imem_addr.

## Test plan
- Reset, ROM holds word i = 0x1000+i, if_ready=1: if_instr sequence 0x1000,0x1001,... with if_pc 0,4,8,...; first if_valid one cycle after reset release.
- if_ready low 5 cycles from PC 8: count saturates at 2 (entries PC 8, 12), imem_addr holds 4; on release, 8,12,16 delivered with no loss or duplicate.
- Redirect to 0x45 while FIFO full: next cycle if_valid=0, imem_addr=17; following cycle if_pc=0x44; stale entries never appear.
- ADDR_W=5, straight-line past PC 124: if_pc 124 followed by 0.
- HALT_INSTR at PC 12: PCs 0..12 delivered, then if_valid stays 0, halted=1 once PC 12 popped; redirect to 0 clears halted and fetch resumes.
- rst_n pulsed low mid-stream with count=2: if_valid, halted drop asynchronously; restart at RESET_PC.
